// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the 5-stage pipelined CPU.
//   - DATA_WIDTH / REG_ADDR_WIDTH : default datapath and register-index widths
//   - load_size_e                 : sub-word load size encoding from MEM/WB
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;

  // 2'b11 is reserved and is handled exactly like a word load.
  typedef enum logic [1:0] {
    LS_WORD = 2'b00,
    LS_HALF = 2'b01,
    LS_BYTE = 2'b10,
    LS_RSVD = 2'b11
  } load_size_e;

endpackage : cpu_pkg

// File: rtl/load_formatter.sv
// -----------------------------------------------------------------------------
// load_formatter
//   Combinational extraction and extension of sub-word loads.
//   Ports:
//     dm_data_out   in  DATA_WIDTH  raw word read from data memory
//     load_size     in  2           00 word, 01 half, 10 byte, 11 word
//     load_unsigned in  1           1 = zero-extend, 0 = sign-extend
//     addr_low      in  2           byte address [1:0] (lane select)
//     load_data     out DATA_WIDTH  formatted load value
//   Lane positions assume a 32-bit memory word in the low bits of dm_data_out.
// -----------------------------------------------------------------------------
module load_formatter
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] dm_data_out,
  input  logic [1:0]            load_size,
  input  logic                  load_unsigned,
  input  logic [1:0]            addr_low,
  output logic [DATA_WIDTH-1:0] load_data
);

  logic [15:0] lane_half;
  logic [7:0]  lane_byte;
  logic        fill_half;
  logic        fill_byte;

  // NOTE: every variable driven here gets a value before any branch,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    lane_half = addr_low[1] ? dm_data_out[31:16] : dm_data_out[15:0];

    lane_byte = dm_data_out[7:0];
    case (addr_low)
      2'd1:    lane_byte = dm_data_out[15:8];
      2'd2:    lane_byte = dm_data_out[23:16];
      2'd3:    lane_byte = dm_data_out[31:24];
      default: lane_byte = dm_data_out[7:0];
    endcase

    // Extension bit: lane MSB for signed loads, zero for unsigned loads.
    fill_half = ~load_unsigned & lane_half[15];
    fill_byte = ~load_unsigned & lane_byte[7];

    load_data = dm_data_out;
    case (load_size_e'(load_size))
      LS_HALF: load_data = {{(DATA_WIDTH-16){fill_half}}, lane_half};
      LS_BYTE: load_data = {{(DATA_WIDTH-8){fill_byte}}, lane_byte};
      default: load_data = dm_data_out;
    endcase
  end

endmodule : load_formatter

// File: rtl/write_back_stage.sv
// -----------------------------------------------------------------------------
// write_back_stage
//   Final pipeline stage: selects ALU result or formatted load, then registers
//   the register-file write value, destination index and write enable.
//   Ports:
//     clk, reset     single clock; synchronous active-high reset
//     mem_to_reg     1 = formatted load, 0 = ALU result
//     alu_data_out   ALU result from MEM/WB
//     dm_data_out    raw data-memory word
//     load_size      sub-word size (see cpu_pkg::load_size_e)
//     load_unsigned  1 = zero-extend sub-word load
//     addr_low       byte address [1:0] of the load
//     reg_write_in   register-file write request
//     rd_in          destination register index
//     wb_data        registered write-back value
//     reg_write_out  registered write enable (never set for register 0)
//     rd_out         registered destination index
// -----------------------------------------------------------------------------
module write_back_stage
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH     = cpu_pkg::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = cpu_pkg::REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mem_to_reg,
  input  logic [DATA_WIDTH-1:0]     alu_data_out,
  input  logic [DATA_WIDTH-1:0]     dm_data_out,
  input  logic [1:0]                load_size,
  input  logic                      load_unsigned,
  input  logic [1:0]                addr_low,
  input  logic                      reg_write_in,
  input  logic [REG_ADDR_WIDTH-1:0] rd_in,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      reg_write_out,
  output logic [REG_ADDR_WIDTH-1:0] rd_out
);

  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] wb_next;

  load_formatter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_load_formatter (
    .dm_data_out   (dm_data_out),
    .load_size     (load_size),
    .load_unsigned (load_unsigned),
    .addr_low      (addr_low),
    .load_data     (load_data)
  );

  // The ALU branch takes alu_data_out directly, so the load sideband
  // cannot influence wb_data when mem_to_reg is low.
  always_comb begin
    wb_next = alu_data_out;
    if (mem_to_reg) begin
      wb_next = load_data;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_data       <= '0;
      reg_write_out <= 1'b0;
      rd_out        <= '0;
    end else begin
      wb_data       <= wb_next;
      // Register 0 is hard-wired to zero; never request a write to it.
      reg_write_out <= reg_write_in && (rd_in != '0);
      rd_out        <= rd_in;
    end
  end

endmodule : write_back_stage

// File: tb/tb_write_back_stage.sv
// -----------------------------------------------------------------------------
// tb_write_back_stage
//   Directed vectors for write_back_stage. The driver pushes the hand-computed
//   response of each vector into a queue; the monitor pops one entry per clock
//   edge after the vector is captured and compares all three outputs.
// -----------------------------------------------------------------------------
module tb_write_back_stage;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        rw;
    logic [4:0]  rd;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        mem_to_reg;
  logic [31:0] alu_data_out;
  logic [31:0] dm_data_out;
  logic [1:0]  load_size;
  logic        load_unsigned;
  logic [1:0]  addr_low;
  logic        reg_write_in;
  logic [4:0]  rd_in;
  logic [31:0] wb_data;
  logic        reg_write_out;
  logic [4:0]  rd_out;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  write_back_stage dut (
    .clk           (clk),
    .reset         (reset),
    .mem_to_reg    (mem_to_reg),
    .alu_data_out  (alu_data_out),
    .dm_data_out   (dm_data_out),
    .load_size     (load_size),
    .load_unsigned (load_unsigned),
    .addr_low      (addr_low),
    .reg_write_in  (reg_write_in),
    .rd_in         (rd_in),
    .wb_data       (wb_data),
    .reg_write_out (reg_write_out),
    .rd_out        (rd_out)
  );

  // 2 ns clock period.
  initial begin
    clk = 1'b0;
    forever #1 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one vector on the falling edge; it is captured on the next rising edge.
  task automatic apply(input string name, input logic rst, input logic m2r,
                       input logic [31:0] alu, input logic [31:0] dm,
                       input logic [1:0] ls, input logic lu, input logic [1:0] al,
                       input logic rw, input logic [4:0] rd,
                       input logic [31:0] e_data, input logic e_rw, input logic [4:0] e_rd);
    exp_t e;
    @(negedge clk);
    reset         = rst;
    mem_to_reg    = m2r;
    alu_data_out  = alu;
    dm_data_out   = dm;
    load_size     = ls;
    load_unsigned = lu;
    addr_low      = al;
    reg_write_in  = rw;
    rd_in         = rd;
    e.name = name;
    e.data = e_data;
    e.rw   = e_rw;
    e.rd   = e_rd;
    exp_q.push_back(e);
  endtask

  // Monitor: one registered result per rising edge, sampled 0.5 ns later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #0.5;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".wb_data"}, wb_data, e.data);
        check({e.name, ".reg_write_out"}, {31'd0, reg_write_out}, {31'd0, e.rw});
        check({e.name, ".rd_out"}, {27'd0, rd_out}, {27'd0, e.rd});
      end
    end
  end

  initial begin
    int wait_cycles;
    reset = 1'b1; mem_to_reg = 1'b0; alu_data_out = '0; dm_data_out = '0;
    load_size = 2'b00; load_unsigned = 1'b0; addr_low = 2'b00;
    reg_write_in = 1'b0; rd_in = '0;

    // Reset state, with non-zero inputs present.
    apply("reset", 1, 0, 32'h1234_5678, 32'h0, 2'b00, 0, 2'd0, 1, 5'd9, 32'h0, 0, 5'd0);

    // ALU path held for 30 ns.
    for (int i = 0; i < 15; i++)
      apply("alu_5", 0, 0, 32'd5, 32'd4, 2'b00, 0, 2'd0, 0, 5'd0, 32'd5, 0, 5'd0);

    // Word loads: addr_low ignored; reserved size behaves as word.
    apply("word", 0, 1, 32'h0, 32'hDEAD_BEEF, 2'b00, 0, 2'd3, 0, 5'd0, 32'hDEAD_BEEF, 0, 5'd0);
    apply("rsvd", 0, 1, 32'h0, 32'hCAFE_F00D, 2'b11, 0, 2'd1, 0, 5'd0, 32'hCAFE_F00D, 0, 5'd0);

    // Byte loads across lanes, signed and unsigned.
    apply("byte2_s", 0, 1, 32'h0, 32'h12F4_5678, 2'b10, 0, 2'd2, 0, 5'd0, 32'hFFFF_FFF4, 0, 5'd0);
    apply("byte2_u", 0, 1, 32'h0, 32'h12F4_5678, 2'b10, 1, 2'd2, 0, 5'd0, 32'h0000_00F4, 0, 5'd0);
    apply("byte0_s", 0, 1, 32'h0, 32'h12F4_5678, 2'b10, 0, 2'd0, 0, 5'd0, 32'h0000_0078, 0, 5'd0);
    apply("byte1_s", 0, 1, 32'h0, 32'h12F4_5678, 2'b10, 0, 2'd1, 0, 5'd0, 32'h0000_0056, 0, 5'd0);
    apply("byte3_s", 0, 1, 32'h0, 32'h12F4_5678, 2'b10, 0, 2'd3, 0, 5'd0, 32'h0000_0012, 0, 5'd0);
    apply("byte1_neg", 0, 1, 32'h0, 32'h0000_8000, 2'b10, 0, 2'd1, 0, 5'd0, 32'hFFFF_FF80, 0, 5'd0);

    // Half loads; addr_low[0] ignored.
    apply("half2_s", 0, 1, 32'h0, 32'h8001_7FFF, 2'b01, 0, 2'd2, 0, 5'd0, 32'hFFFF_8001, 0, 5'd0);
    apply("half0_s", 0, 1, 32'h0, 32'h8001_7FFF, 2'b01, 0, 2'd0, 0, 5'd0, 32'h0000_7FFF, 0, 5'd0);
    apply("half3_u", 0, 1, 32'h0, 32'h8001_7FFF, 2'b01, 1, 2'd3, 0, 5'd0, 32'h0000_8001, 0, 5'd0);
    apply("half1_s", 0, 1, 32'h0, 32'h8001_7FFF, 2'b01, 0, 2'd1, 0, 5'd0, 32'h0000_7FFF, 0, 5'd0);

    // ALU path must ignore busy load sideband.
    apply("alu_side", 0, 0, 32'hA5A5_5A5A, 32'hFFFF_FFFF, 2'b10, 0, 2'd3, 0, 5'd0, 32'hA5A5_5A5A, 0, 5'd0);

    // Write-enable / destination handling.
    apply("rd0_suppr", 0, 0, 32'h1, 32'h0, 2'b00, 0, 2'd0, 1, 5'd0, 32'h1, 0, 5'd0);
    apply("rd7_write", 0, 0, 32'h2, 32'h0, 2'b00, 0, 2'd0, 1, 5'd7, 32'h2, 1, 5'd7);
    apply("rd31_nowr", 0, 0, 32'h3, 32'h0, 2'b00, 0, 2'd0, 0, 5'd31, 32'h3, 0, 5'd31);

    // Reset mid-stream, then resume.
    apply("mid_reset", 1, 0, 32'd9, 32'h0, 2'b00, 0, 2'd0, 1, 5'd3, 32'h0, 0, 5'd0);
    apply("post_reset", 0, 0, 32'd9, 32'h0, 2'b00, 0, 2'd0, 1, 5'd3, 32'd9, 1, 5'd3);

    // Bounded drain of the scoreboard.
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_write_back_stage
